// File: rtl/sram_copy_engine_if.sv
// Command and SRAM-port bundle for sram_copy_engine.
// The engine uses the slave view; the controller/SRAM side uses master.
interface sram_copy_engine_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_src;
  logic [ADDR_W-1:0] cmd_dst;
  logic [ADDR_W:0]   cmd_len;
  logic [DATA_W-1:0] cmd_pattern;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;
  logic              done;
  logic              err;
  logic [DATA_W-1:0] result;

  modport slave (
    input  cmd_valid, cmd_op, cmd_src, cmd_dst, cmd_len, cmd_pattern, mem_rdata,
    output cmd_ready, mem_we, mem_addr, mem_wdata, busy, done, err, result
  );

  modport master (
    output cmd_valid, cmd_op, cmd_src, cmd_dst, cmd_len, cmd_pattern, mem_rdata,
    input  cmd_ready, mem_we, mem_addr, mem_wdata, busy, done, err, result
  );
endinterface

// File: rtl/sram_copy_engine.sv
// Block FILL / COPY / CHECKSUM engine driving a single-port synchronous SRAM
// with one-cycle read latency.
module sram_copy_engine #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  sram_copy_engine_if.slave   bus
);
  typedef enum logic [2:0] {
    IDLE, FILL, COPY_RD, COPY_WR, SUM, DRAIN, DONE
  } state_t;

  localparam logic [1:0]    OP_FILL = 2'b00;
  localparam logic [1:0]    OP_COPY = 2'b01;
  localparam logic [1:0]    OP_SUM  = 2'b10;
  localparam logic [1:0]    OP_RSVD = 2'b11;
  localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE     = {{ADDR_W{1'b0}}, 1'b1};

  state_t            state_reg;
  logic [ADDR_W-1:0] src_reg;
  logic [ADDR_W-1:0] dst_reg;
  logic [ADDR_W:0]   len_reg;
  logic [ADDR_W:0]   idx_reg;
  logic [DATA_W-1:0] pattern_reg;
  logic [DATA_W-1:0] acc_reg;
  logic [DATA_W-1:0] result_reg;
  logic              we_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic              done_reg;
  logic              err_reg;

  logic [ADDR_W-1:0] idx_lo;
  logic [ADDR_W:0]   idx_inc;

  assign idx_lo  = idx_reg[ADDR_W-1:0];
  assign idx_inc = idx_reg + ONE;

  assign bus.cmd_ready = (state_reg == IDLE) && !rst;
  assign bus.busy      = (state_reg != IDLE);
  // Write enable is gated by reset so an abort never lands a stray write.
  assign bus.mem_we    = we_reg & ~rst;
  assign bus.mem_addr  = addr_reg;
  // Copy writes forward the word read in the previous cycle straight through.
  assign bus.mem_wdata = (state_reg == COPY_WR) ? bus.mem_rdata : wdata_reg;
  assign bus.done      = done_reg;
  assign bus.err       = err_reg;
  assign bus.result    = result_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      src_reg     <= '0;
      dst_reg     <= '0;
      len_reg     <= '0;
      idx_reg     <= '0;
      pattern_reg <= '0;
      acc_reg     <= '0;
      result_reg  <= '0;
      we_reg      <= 1'b0;
      addr_reg    <= '0;
      wdata_reg   <= '0;
      done_reg    <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      // Outputs are registered: each branch sets what the next cycle drives.
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
      unique case (state_reg)
        IDLE: begin
          if (bus.cmd_valid) begin
            src_reg     <= bus.cmd_src;
            dst_reg     <= bus.cmd_dst;
            len_reg     <= bus.cmd_len;
            pattern_reg <= bus.cmd_pattern;
            acc_reg     <= '0;
            idx_reg     <= '0;
            if (bus.cmd_op == OP_RSVD || bus.cmd_len > MAX_LEN) begin
              state_reg <= DONE;
              done_reg  <= 1'b1;
              err_reg   <= 1'b1;
            end else if (bus.cmd_len == '0) begin
              state_reg <= DONE;
              done_reg  <= 1'b1;
              if (bus.cmd_op == OP_SUM) result_reg <= '0;
            end else if (bus.cmd_op == OP_FILL) begin
              state_reg <= FILL;
              we_reg    <= 1'b1;
              addr_reg  <= bus.cmd_dst;
              wdata_reg <= bus.cmd_pattern;
              idx_reg   <= ONE;
            end else if (bus.cmd_op == OP_COPY) begin
              state_reg <= COPY_RD;
              addr_reg  <= bus.cmd_src;
            end else begin
              state_reg <= SUM;
              addr_reg  <= bus.cmd_src;
              idx_reg   <= ONE;
            end
          end
        end
        FILL: begin
          if (idx_reg == len_reg) begin
            state_reg <= DONE;
            done_reg  <= 1'b1;
          end else begin
            we_reg    <= 1'b1;
            addr_reg  <= dst_reg + idx_lo;
            wdata_reg <= pattern_reg;
            idx_reg   <= idx_inc;
          end
        end
        COPY_RD: begin
          state_reg <= COPY_WR;
          we_reg    <= 1'b1;
          addr_reg  <= dst_reg + idx_lo;
        end
        COPY_WR: begin
          if (idx_inc == len_reg) begin
            state_reg <= DONE;
            done_reg  <= 1'b1;
          end else begin
            state_reg <= COPY_RD;
            addr_reg  <= src_reg + idx_inc[ADDR_W-1:0];
            idx_reg   <= idx_inc;
          end
        end
        SUM: begin
          // The first cycle has no read data returned yet.
          if (idx_reg != ONE) acc_reg <= acc_reg + bus.mem_rdata;
          if (idx_reg == len_reg) begin
            state_reg <= DRAIN;
          end else begin
            addr_reg <= src_reg + idx_lo;
            idx_reg  <= idx_inc;
          end
        end
        DRAIN: begin
          result_reg <= acc_reg + bus.mem_rdata;
          state_reg  <= DONE;
          done_reg   <= 1'b1;
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sram_copy_engine.sv
// Directed bench for sram_copy_engine: SRAM model, reference memory model
// producing a per-cycle expectation trace, and literal spot checks.
module tb_sram_copy_engine;
  localparam int AW = 10;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sram_copy_engine_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  sram_copy_engine #(.ADDR_W(AW), .DATA_W(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

  // SRAM model with a bench-side preload port
  logic [31:0] sram [0:1023];
  logic        pl_we   = 1'b0;
  logic [9:0]  pl_addr = '0;
  logic [31:0] pl_data = '0;
  always @(posedge clk) begin
    if (pl_we) sram[pl_addr] <= pl_data;
    else if (bus.mem_we) sram[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= sram[bus.mem_addr];
  end

  // Reference model state
  logic [31:0] ref_mem [0:1023];
  bit          known   [0:1023];
  logic [31:0] exp_result = '0;

  typedef struct {
    bit          ready;
    bit          chk_busy;
    bit          busy;
    bit          we;
    bit          chk_addr;
    logic [9:0]  addr;
    bit          chk_wdata;
    logic [31:0] wdata;
    bit          done;
    bit          err;
    logic [31:0] result;
  } exp_t;
  exp_t exp_q[$];

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", nm, act, expv, $time);
  endtask

  task automatic push_e(bit rdy, bit cb, bit bsy, bit we, bit ca, logic [9:0] a,
                        bit cw, logic [31:0] d, bit dn, bit er);
    exp_t e;
    e.ready = rdy; e.chk_busy = cb; e.busy = bsy; e.we = we;
    e.chk_addr = ca; e.addr = a; e.chk_wdata = cw; e.wdata = d;
    e.done = dn; e.err = er; e.result = exp_result;
    exp_q.push_back(e);
  endtask

  task automatic push_idle();
    push_e(1, 1, 0, 0, 1, 10'd0, 1, 32'd0, 0, 0);
  endtask

  task automatic push_copy_words(logic [9:0] src, logic [9:0] dst, int n);
    for (int i = 0; i < n; i++) begin
      logic [9:0]  s, t;
      logic [31:0] d;
      s = src + 10'(i);
      t = dst + 10'(i);
      d = ref_mem[s];
      push_e(0, 1, 1, 0, 1, s, 0, 32'd0, 0, 0);
      push_e(0, 1, 1, 1, 1, t, 1, d, 0, 0);
      ref_mem[t] = d;
      known[t] = 1'b1;
    end
  endtask

  // Expected trace from the acceptance cycle through the done cycle.
  task automatic push_cmd(logic [1:0] op, logic [9:0] src, logic [9:0] dst, int len,
                          logic [31:0] pat);
    bit reject;
    logic [31:0] sum;
    push_e(1, 1, 0, 0, 1, 10'd0, 1, 32'd0, 0, 0);
    reject = (op == 2'b11) || (len > 1024);
    if (reject || len == 0) begin
      if (!reject && op == 2'b10) exp_result = 32'd0;
      push_e(0, 1, 1, 0, 1, 10'd0, 1, 32'd0, 1, reject);
      return;
    end
    case (op)
      2'b00: begin
        for (int i = 0; i < len; i++) begin
          logic [9:0] a;
          a = dst + 10'(i);
          push_e(0, 1, 1, 1, 1, a, 1, pat, 0, 0);
          ref_mem[a] = pat;
          known[a] = 1'b1;
        end
      end
      2'b01: push_copy_words(src, dst, len);
      default: begin
        sum = 32'd0;
        for (int i = 0; i < len; i++) begin
          logic [9:0] a;
          a = src + 10'(i);
          push_e(0, 1, 1, 0, 1, a, 0, 32'd0, 0, 0);
          sum = sum + ref_mem[a];
        end
        push_e(0, 1, 1, 0, 0, 10'd0, 0, 32'd0, 0, 0);
        exp_result = sum;
      end
    endcase
    push_e(0, 1, 1, 0, 1, 10'd0, 1, 32'd0, 1, 0);
  endtask

  // Single compare process: one expectation per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("cmd_ready", 32'(bus.cmd_ready), 32'(e.ready));
      if (e.chk_busy) chk("busy", 32'(bus.busy), 32'(e.busy));
      chk("mem_we", 32'(bus.mem_we), 32'(e.we));
      if (e.chk_addr) chk("mem_addr", 32'(bus.mem_addr), 32'(e.addr));
      if (e.chk_wdata) chk("mem_wdata", bus.mem_wdata, e.wdata);
      chk("done", 32'(bus.done), 32'(e.done));
      chk("err", 32'(bus.err), 32'(e.err));
      chk("result", bus.result, e.result);
    end
  end

  task automatic drive_cmd(logic [1:0] op, logic [9:0] src, logic [9:0] dst, int len,
                           logic [31:0] pat);
    bus.cmd_op = op; bus.cmd_src = src; bus.cmd_dst = dst;
    bus.cmd_len = 11'(len); bus.cmd_pattern = pat;
  endtask

  task automatic wait_drain();
    while (exp_q.size() != 0) @(negedge clk);
  endtask

  task automatic run_cmd(logic [1:0] op, logic [9:0] src, logic [9:0] dst, int len,
                         logic [31:0] pat);
    @(posedge clk); #1;
    drive_cmd(op, src, dst, len, pat);
    bus.cmd_valid = 1'b1;
    push_cmd(op, src, dst, len, pat);
    push_idle();
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    wait_drain();
    $display("cmd op=%0d src=0x%03h dst=0x%03h len=%0d -> done err=%0d result=0x%08h",
             op, src, dst, len, bus.err, bus.result);
  endtask

  task automatic preload(logic [9:0] a, logic [31:0] d);
    @(posedge clk); #1;
    pl_we = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clk); #1;
    pl_we = 1'b0;
    ref_mem[a] = d;
    known[a] = 1'b1;
  endtask

  initial begin
    int mism;
    bus.cmd_valid = 1'b0;
    drive_cmd(2'b00, 10'd0, 10'd0, 0, 32'd0);

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_result", bus.result, 32'd0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // FILL wrapping the top of memory
    run_cmd(2'b00, 10'd0, 10'h3FE, 4, 32'hA5A5_0001);
    chk("fill_3fe", sram[10'h3FE], 32'hA5A5_0001);
    chk("fill_001", sram[10'h001], 32'hA5A5_0001);

    // COPY 8 words
    for (int i = 0; i < 8; i++) preload(10'h010 + 10'(i), 32'(i + 1));
    run_cmd(2'b01, 10'h010, 10'h100, 8, 32'd0);
    chk("copy_100", sram[10'h100], 32'd1);
    chk("copy_107", sram[10'h107], 32'd8);

    // CHECKSUM over the copy
    run_cmd(2'b10, 10'h100, 10'd0, 8, 32'd0);
    chk("sum_36", bus.result, 32'd36);
    chk("model_sum_36", exp_result, 32'd36);

    // CHECKSUM wrapping mod 2^32
    preload(10'h200, 32'hFFFF_FFFF);
    preload(10'h201, 32'h0000_0002);
    run_cmd(2'b10, 10'h200, 10'd0, 2, 32'd0);
    chk("sum_wrap", bus.result, 32'd1);

    // Rejected and empty commands
    run_cmd(2'b11, 10'h010, 10'h180, 4, 32'hDEAD_0000);
    run_cmd(2'b00, 10'd0, 10'h180, 1025, 32'hBEEF_0000);
    chk("reject_result_held", bus.result, 32'd1);
    run_cmd(2'b00, 10'd0, 10'h180, 0, 32'hBEEF_0001);
    run_cmd(2'b10, 10'h100, 10'd0, 0, 32'd0);
    chk("sum_len0", bus.result, 32'd0);

    // Reset in cycle 5 of an 8-word COPY
    for (int i = 0; i < 8; i++) preload(10'h010 + 10'(i), 32'h100 + 32'(i));
    @(posedge clk); #1;
    drive_cmd(2'b01, 10'h010, 10'h100, 8, 32'd0);
    bus.cmd_valid = 1'b1;
    push_e(1, 1, 0, 0, 1, 10'd0, 1, 32'd0, 0, 0);
    push_copy_words(10'h010, 10'h100, 2);
    push_e(0, 0, 0, 0, 0, 10'd0, 0, 32'd0, 0, 0);
    exp_result = 32'd0;
    push_idle();
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    wait_drain();
    $display("cmd copy aborted by reset in cycle 5");
    chk("abort_100", sram[10'h100], 32'h100);
    chk("abort_101", sram[10'h101], 32'h101);
    chk("abort_102", sram[10'h102], 32'd3);

    // Overlapping COPY with dst > src recopies already-overwritten words
    run_cmd(2'b01, 10'h100, 10'h102, 4, 32'd0);
    chk("overlap_104", sram[10'h104], 32'h100);
    chk("overlap_105", sram[10'h105], 32'h101);

    // Back-to-back: FILL then CHECKSUM with cmd_valid held high
    @(posedge clk); #1;
    drive_cmd(2'b00, 10'd0, 10'h300, 3, 32'h1111_1111);
    bus.cmd_valid = 1'b1;
    push_cmd(2'b00, 10'd0, 10'h300, 3, 32'h1111_1111);
    push_cmd(2'b10, 10'h300, 10'd0, 3, 32'd0);
    push_idle();
    @(posedge clk); #1;
    drive_cmd(2'b10, 10'h300, 10'd0, 3, 32'd0);
    repeat (5) @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    wait_drain();
    $display("cmd back-to-back fill+checksum result=0x%08h", bus.result);
    chk("b2b_sum", bus.result, 32'h3333_3333);

    // Whole-memory agreement with the reference model
    mism = 0;
    for (int a = 0; a < 1024; a++)
      if (known[a] && sram[a] !== ref_mem[a]) mism++;
    chk("mem_sweep_mismatches", 32'(mism), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
